// File: rtl/test_card_sequencer.sv
// test_card_sequencer
//   Frame-synchronous scheduler that picks one of CARDS test card pixel
//   streams and registers it for the display controller. The selection
//   advances every FRAMES_PER_CARD frames (0 = never) or on a rising edge
//   of i_next. Card changes are applied only on i_frame, so a frame never
//   mixes two cards.
//
//   Optional feature (macro SEQ_BLANK_EN): each advance inserts
//   BLANK_FRAMES black frames before the new card is shown.
//
// Ports
//   i_clk    pixel clock
//   i_rst    asynchronous active-high reset
//   i_frame  one-cycle frame-start pulse (during blanking)
//   i_de     data enable, high on active pixels
//   i_next   manual advance request (rising edge = one request)
//   i_pause  suspends auto-advance while high
//   i_rgb    packed card pixels, card k at [k*24 +: 24] as {R,G,B}
//   o_card   index of the card currently shown
//   o_switch one-cycle pulse when o_card has just changed
//   o_red/o_green/o_blue  registered pixel output
module test_card_sequencer #(
  parameter int CARDS           = 4,
  parameter int FRAMES_PER_CARD = 120,
  parameter int BLANK_FRAMES    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame,
  input  logic                  i_de,
  input  logic                  i_next,
  input  logic                  i_pause,
  input  logic [CARDS*24-1:0]   i_rgb,
  output logic [2:0]            o_card,
  output logic                  o_switch,
  output logic [7:0]            o_red,
  output logic [7:0]            o_green,
  output logic [7:0]            o_blue
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_PAUSED = 2'd1;
  localparam logic [1:0] ST_BLANK  = 2'd2;

  // Counter only needs to reach FRAMES_PER_CARD-1.
  localparam int             FCW       = (FRAMES_PER_CARD > 1) ? $clog2(FRAMES_PER_CARD) : 1;
  localparam logic [FCW-1:0] FC_LAST   = FCW'((FRAMES_PER_CARD > 0) ? FRAMES_PER_CARD - 1 : 0);
  localparam bit             AUTO_ON   = (FRAMES_PER_CARD != 0);
  localparam logic [2:0]     CARD_LAST = 3'(CARDS - 1);

  logic [1:0]     state;
  logic [FCW-1:0] fcnt;
  logic           pending;
  logic           next_q;
  logic           next_edge;
  logic           req;
  logic           auto_due;
  logic           in_blank;
  logic           advance;
  logic [23:0]    pix;

  logic [CARDS-1:0][23:0] rgb_a;
  assign rgb_a = i_rgb;

  // An edge coincident with i_frame counts for that frame.
  assign next_edge = i_next & ~next_q;
  assign req       = pending | next_edge;
  assign auto_due  = AUTO_ON && (state == ST_RUN) && (fcnt == FC_LAST);

`ifdef SEQ_BLANK_EN
  localparam bit             BLANK_ON = (BLANK_FRAMES > 0);
  localparam int             BCW      = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam logic [BCW-1:0] BC_LAST  = BCW'(BLANK_ON ? BLANK_FRAMES - 1 : 0);

  logic [BCW-1:0] bcnt;
  logic           blank_done;

  assign in_blank   = (state == ST_BLANK);
  assign blank_done = in_blank && (bcnt == BC_LAST);
  // Inside BLANK only a held request can advance, and only on the exit frame.
  assign advance    = i_frame && (in_blank ? (blank_done && req) : (req || auto_due));
`else
  assign in_blank   = 1'b0;
  assign advance    = i_frame && (req || auto_due);
`endif

  // Explicit compare chain keeps o_card from indexing past CARDS-1.
  always_comb begin
    pix = 24'h0;
    for (int k = 0; k < CARDS; k++)
      if (o_card == 3'(k)) pix = rgb_a[k];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_RUN;
      fcnt     <= '0;
      pending  <= 1'b0;
      next_q   <= 1'b0;
      o_card   <= 3'd0;
      o_switch <= 1'b0;
      o_red    <= 8'h0;
      o_green  <= 8'h0;
      o_blue   <= 8'h0;
`ifdef SEQ_BLANK_EN
      bcnt     <= '0;
`endif
    end else begin
      next_q   <= i_next;
      o_switch <= advance;

      // Auto-advance and a request on the same frame collapse into one step.
      if (advance) begin
        o_card  <= (o_card == CARD_LAST) ? 3'd0 : o_card + 3'd1;
        fcnt    <= '0;
        pending <= 1'b0;
      end else begin
        if (next_edge) pending <= 1'b1;
        if (i_frame && state == ST_RUN && AUTO_ON) fcnt <= fcnt + 1'b1;
      end

      if (i_frame) begin
`ifdef SEQ_BLANK_EN
        if (advance && BLANK_ON) begin
          state <= ST_BLANK;
          bcnt  <= '0;
        end else if (in_blank) begin
          if (blank_done) state <= i_pause ? ST_PAUSED : ST_RUN;
          else            bcnt  <= bcnt + 1'b1;
        end else begin
          state <= i_pause ? ST_PAUSED : ST_RUN;
        end
`else
        state <= i_pause ? ST_PAUSED : ST_RUN;
`endif
      end

      if (i_de && !in_blank) {o_red, o_green, o_blue} <= pix;
      else                   {o_red, o_green, o_blue} <= 24'h0;
    end
  end

endmodule

// File: tb/tb_test_card_sequencer.sv
// Bench for test_card_sequencer (default build). Two instances share
// clock, reset, frame timing, pixels and pause: dut_a auto-advances every
// 2 frames, dut_b has auto-advance disabled and is used for manual requests.
module tb_test_card_sequencer;

  localparam int CARDS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame = 1'b0, de = 1'b0, pause = 1'b0;
  logic next_a = 1'b0, next_b = 1'b0;
  logic [CARDS*24-1:0] rgb;

  logic [2:0] card_a, card_b;
  logic       sw_a, sw_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;

  int n_checks = 0;
  int n_fails  = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  test_card_sequencer #(.CARDS(CARDS), .FRAMES_PER_CARD(2), .BLANK_FRAMES(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_frame(frame), .i_de(de), .i_next(next_a),
    .i_pause(pause), .i_rgb(rgb), .o_card(card_a), .o_switch(sw_a),
    .o_red(r_a), .o_green(g_a), .o_blue(b_a));

  test_card_sequencer #(.CARDS(CARDS), .FRAMES_PER_CARD(0), .BLANK_FRAMES(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_frame(frame), .i_de(de), .i_next(next_b),
    .i_pause(pause), .i_rgb(rgb), .o_card(card_b), .o_switch(sw_b),
    .o_red(r_b), .o_green(g_b), .o_blue(b_b));

  function automatic logic [23:0] cardpix(input int k);
    return 24'h102030 + 24'(k) * 24'h111111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: expected pixel is queued as stimulus is driven and compared
  // once the registered output appears after the edge.
  task automatic cyc(input logic f, input logic d, input int card);
    frame = f;
    de    = d;
    exp_q.push_back(d ? cardpix(card) : 24'h0);
    @(posedge clk); #1;
    chk("pix_a", {8'h0, r_a, g_a, b_a}, {8'h0, exp_q.pop_front()});
  endtask

  // Frame: pulse, one blanking cycle, 4 active pixels, one blanking cycle.
  task automatic do_frame(input int ca, input logic sa, input int cb, input logic sb,
                          input logic na);
    next_a = na;
    cyc(1'b1, 1'b0, 0);
    chk("card_a", 32'(card_a), 32'(ca));
    chk("sw_a",   32'(sw_a),   32'(sa));
    chk("card_b", 32'(card_b), 32'(cb));
    chk("sw_b",   32'(sw_b),   32'(sb));
    next_a = 1'b0;
    cyc(1'b0, 1'b0, 0);
    chk("sw_a_once", 32'(sw_a), 32'd0);
    chk("sw_b_once", 32'(sw_b), 32'd0);
    repeat (4) cyc(1'b0, 1'b1, ca);
    cyc(1'b0, 1'b0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < CARDS; k++) rgb[k*24 +: 24] = cardpix(k);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_card_a", 32'(card_a), 32'd0);
    chk("rst_sw_a",   32'(sw_a),   32'd0);
    chk("rst_rgb_a",  {8'h0, r_a, g_a, b_a}, 32'h0);
    chk("rst_card_b", 32'(card_b), 32'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 0);

    // Auto-advance after two frames
    do_frame(0, 1'b0, 0, 1'b0, 1'b0);
    do_frame(1, 1'b1, 0, 1'b0, 1'b0);

    // Two mid-frame next edges on dut_b collapse into one advance
    next_b = 1'b1; cyc(1'b0, 1'b0, 0);
    next_b = 1'b0; cyc(1'b0, 1'b0, 0);
    next_b = 1'b1; cyc(1'b0, 1'b0, 0);
    next_b = 1'b0; cyc(1'b0, 1'b0, 0);
    chk("card_b_before_frame", 32'(card_b), 32'd0);
    do_frame(1, 1'b0, 1, 1'b1, 1'b0);
    do_frame(2, 1'b1, 1, 1'b0, 1'b0);
    do_frame(2, 1'b0, 1, 1'b0, 1'b0);

    // Pause: the frame that sees pause while in RUN still counts (fcnt was 1)
    pause = 1'b1;
    do_frame(3, 1'b1, 1, 1'b0, 1'b0);
    repeat (9) do_frame(3, 1'b0, 1, 1'b0, 1'b0);
    pause = 1'b0;
    do_frame(3, 1'b0, 1, 1'b0, 1'b0);   // back to RUN, fcnt held at 0
    do_frame(3, 1'b0, 1, 1'b0, 1'b0);   // fcnt -> 1

    // Next edge coincident with auto-advance-due frame: single wrap to 0
    do_frame(0, 1'b1, 1, 1'b0, 1'b1);
    do_frame(0, 1'b0, 1, 1'b0, 1'b0);
    do_frame(1, 1'b1, 1, 1'b0, 1'b0);
    do_frame(1, 1'b0, 1, 1'b0, 1'b0);
    do_frame(2, 1'b1, 1, 1'b0, 1'b0);

    // Asynchronous reset mid-line with a pending request on card 2
    next_a = 1'b1; cyc(1'b0, 1'b0, 0);
    next_a = 1'b0; cyc(1'b0, 1'b1, 2);
    de = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_card_a", 32'(card_a), 32'd0);
    chk("arst_sw_a",   32'(sw_a),   32'd0);
    chk("arst_rgb_a",  {8'h0, r_a, g_a, b_a}, 32'h0);
    chk("arst_card_b", 32'(card_b), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    de  = 1'b0;
    cyc(1'b0, 1'b0, 0);
    do_frame(0, 1'b0, 0, 1'b0, 1'b0);   // request lost, no advance
    do_frame(1, 1'b1, 0, 1'b0, 1'b0);   // counter restarted from 0

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
